// File: rtl/if_fetch_queue.sv
// Instruction fetch: sequential word fetches over req/gnt/rvalid, a small prefetch
// queue with bypass, and the IF/DEC output register obeying stall and flush/redirect.
module if_fetch_queue #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LW_STALL,
    input  logic        DEC_FLUSH,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_ir,
    output logic [31:0] dec_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [31:0] r_fetch_pc;
    cnt_t        r_outstanding, r_discard, r_count;
    logic [31:0] r_q_pc [DEPTH];
    logic [31:0] r_q_ir [DEPTH];
    ptr_t        r_q_head, r_q_tail;
    logic [31:0] r_pf [DEPTH];
    ptr_t        r_pf_rd, r_pf_wr;

    logic        w_room, w_req, w_fire, w_keep, w_pop, w_bypass, w_push;
    logic [31:0] w_rsp_pc, w_redir_pc;

    // Outstanding requests and buffered words share the DEPTH budget, so every
    // granted word is guaranteed a queue slot when it returns.
    assign w_room     = ({1'b0, r_outstanding} + {1'b0, r_count}) < {1'b0, DEPTH_C};
    assign w_req      = RST_N && !DEC_FLUSH && w_room;
    assign w_fire     = w_req && imem_gnt;
    assign w_rsp_pc   = r_pf[r_pf_rd];
    assign w_keep     = imem_rvalid && (r_discard == '0) && !DEC_FLUSH;
    assign w_pop      = !DEC_FLUSH && !LW_STALL && (r_count != '0);
    assign w_bypass   = !DEC_FLUSH && !LW_STALL && (r_count == '0) && w_keep;
    assign w_push     = w_keep && !w_bypass;
    assign w_redir_pc = redirect_pc & ~32'd3;

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_pc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fetch_pc    <= {RESET_VEC[31:2], 2'b00};
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_q_head      <= '0;
            r_q_tail      <= '0;
            r_pf_rd       <= '0;
            r_pf_wr       <= '0;
        end else begin
            if (DEC_FLUSH)
                r_fetch_pc <= w_redir_pc;
            else if (w_fire)
                r_fetch_pc <= r_fetch_pc + 32'd4;

            r_outstanding <= r_outstanding + cnt_t'(w_fire) - cnt_t'(imem_rvalid);
            if (w_fire)
                r_pf_wr <= r_pf_wr + ptr_t'(1);
            if (imem_rvalid)
                r_pf_rd <= r_pf_rd + ptr_t'(1);

            // Everything still unanswered after a flush cycle is stale.
            if (DEC_FLUSH)
                r_discard <= r_outstanding - cnt_t'(imem_rvalid);
            else if (imem_rvalid && (r_discard != '0))
                r_discard <= r_discard - cnt_t'(1);

            if (DEC_FLUSH) begin
                r_count  <= '0;
                r_q_head <= '0;
                r_q_tail <= '0;
            end else begin
                if (w_push)
                    r_q_tail <= r_q_tail + ptr_t'(1);
                if (w_pop)
                    r_q_head <= r_q_head + ptr_t'(1);
                r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fire)
            r_pf[r_pf_wr] <= r_fetch_pc;
        if (w_push) begin
            r_q_pc[r_q_tail] <= w_rsp_pc;
            r_q_ir[r_q_tail] <= imem_rdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dec_valid <= 1'b0;
            dec_ir    <= '0;
            dec_pc    <= '0;
        end else if (DEC_FLUSH) begin
            dec_valid <= 1'b0;
            dec_ir    <= '0;
            dec_pc    <= '0;
        end else if (!LW_STALL) begin
            if (r_count != '0) begin
                dec_valid <= 1'b1;
                dec_ir    <= r_q_ir[r_q_head];
                dec_pc    <= r_q_pc[r_q_head];
            end else if (w_keep) begin
                dec_valid <= 1'b1;
                dec_ir    <= imem_rdata;
                dec_pc    <= w_rsp_pc;
            end else begin
                dec_valid <= 1'b0;
                dec_ir    <= '0;
                dec_pc    <= '0;
            end
        end
    end

    a_budget: assert property (@(posedge CLK) disable iff (!RST_N)
        ({1'b0, r_outstanding} + {1'b0, r_count}) <= {1'b0, DEPTH_C});
    a_rsp_underflow: assert property (@(posedge CLK) disable iff (!RST_N)
        imem_rvalid |-> (r_outstanding != '0));
    a_discard: assert property (@(posedge CLK) disable iff (!RST_N)
        r_discard <= r_outstanding);
    a_q_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(w_push && !w_pop && (r_count == DEPTH_C)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a queue-level reference model plus a
// behavioural instruction memory with variable grant and response latency.
module tb_if_fetch_queue;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] XK    = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST_N, LW_STALL, DEC_FLUSH, imem_gnt, imem_rvalid;
    logic        imem_req, dec_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, dec_ir, dec_pc;

    always #5 CLK = ~CLK;

    if_fetch_queue #(.RESET_VEC(RV), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .LW_STALL(LW_STALL), .DEC_FLUSH(DEC_FLUSH),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ir(dec_ir), .dec_pc(dec_pc)
    );

    typedef struct {logic [31:0] pc; bit stale;} infl_t;
    typedef struct {logic [31:0] pc; logic [31:0] ir;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    infl_t       m_infl[$];
    ent_t        m_q[$];
    mreq_t       mem[$];
    logic [31:0] m_fpc, m_pc, m_ir;
    logic        m_dv;
    int          cyc, last_due, fix_del, n_pass, n_tot;
    bit          gnt_rand, del_rand, s_fire, wrapped;
    logic [31:0] s_addr, prev_pc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic model_reset();
        m_infl.delete(); m_q.delete(); mem.delete();
        m_fpc = RV; m_dv = 1'b0; m_pc = '0; m_ir = '0;
        cyc = 0; last_due = 0;
    endtask

    function automatic bit exp_req();
        return RST_N && !DEC_FLUSH && (m_infl.size() + m_q.size() < DEPTH);
    endfunction

    task automatic model_step();
        bit          keep, req;
        logic [31:0] rpc;
        infl_t       e;
        ent_t        h;
        req = exp_req(); keep = 1'b0; rpc = '0;
        if (imem_rvalid && m_infl.size() > 0) begin
            e = m_infl.pop_front();
            rpc = e.pc;
            keep = !e.stale && !DEC_FLUSH;
        end
        if (DEC_FLUSH) begin
            m_dv = 1'b0; m_pc = '0; m_ir = '0;
            m_q.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_fpc = redirect_pc & ~32'd3;
        end else if (LW_STALL) begin
            if (keep) m_q.push_back('{rpc, imem_rdata});
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_dv = 1'b1; m_pc = h.pc; m_ir = h.ir;
            if (keep) m_q.push_back('{rpc, imem_rdata});
        end else if (keep) begin
            m_dv = 1'b1; m_pc = rpc; m_ir = imem_rdata;
        end else begin
            m_dv = 1'b0; m_pc = '0; m_ir = '0;
        end
        if (req && imem_gnt) begin
            m_infl.push_back('{m_fpc, 1'b0});
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic mem_step();
        int d, due;
        if (imem_rvalid && mem.size() > 0) mem.delete(0);
        if (s_fire) begin
            d = del_rand ? int'($urandom_range(1, 4)) : fix_del;
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem.push_back('{s_addr, due});
        end
        cyc++;
    endtask

    // One clock cycle: drive memory, check request side, edge, check decode side.
    task automatic tick();
        imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[0].addr ^ XK;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) chk("imem_addr", imem_addr, m_fpc);
        s_fire = imem_req && imem_gnt;
        s_addr = imem_addr;
        @(posedge CLK);
        if (RST_N) begin
            model_step();
            mem_step();
        end
        @(negedge CLK);
        chk("dec_valid", 32'(dec_valid), 32'(m_dv));
        chk("dec_pc", dec_pc, m_pc);
        chk("dec_ir", dec_ir, m_ir);
    endtask

    initial begin
        n_pass = 0; n_tot = 0;
        RST_N = 1'b0; LW_STALL = 1'b0; DEC_FLUSH = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_rand = 1'b0; del_rand = 1'b0; fix_del = 1;
        s_fire = 1'b0; s_addr = '0; wrapped = 1'b0; prev_pc = '0;
        model_reset();

        tick(); tick();
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        RST_N = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RV);

        // Zero-wait streaming, then a three-cycle stall at pc 8.
        tick(); tick();
        chk("stream_pc0", dec_pc, 32'd0);
        chk("stream_v0", 32'(dec_valid), 32'd1);
        tick();
        chk("stream_pc4", dec_pc, 32'd4);
        chk("stream_ir4", dec_ir, 32'hA5A5_0004);
        tick();
        chk("stream_pc8", dec_pc, 32'd8);
        LW_STALL = 1'b1;
        tick(); chk("stall_hold1", dec_pc, 32'd8);
        tick(); chk("stall_hold2", dec_pc, 32'd8);
        chk("stall_full_req", 32'(imem_req), 32'd0);
        tick(); chk("stall_hold3", dec_pc, 32'd8);
        LW_STALL = 1'b0;
        tick(); chk("resume_pc12", dec_pc, 32'd12);
        tick(); chk("resume_pc16", dec_pc, 32'd16);
        tick(); chk("resume_pc20", dec_pc, 32'd20);
        chk("resume_v20", 32'(dec_valid), 32'd1);

        // Redirect with two stale requests in flight.
        fix_del = 3;
        for (int i = 0; i < 30 && mem.size() != 2; i++) tick();
        chk("two_outstanding", 32'(mem.size()), 32'd2);
        DEC_FLUSH = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        DEC_FLUSH = 1'b0; redirect_pc = '0;
        chk("redir_bubble_v", 32'(dec_valid), 32'd0);
        chk("redir_bubble_ir", dec_ir, 32'd0);
        for (int i = 0; i < 30 && !dec_valid; i++) tick();
        chk("redir_valid", 32'(dec_valid), 32'd1);
        chk("redir_pc", dec_pc, 32'h0000_0100);

        // Flush together with stall; zero-wait redirect latency.
        fix_del = 1;
        repeat (10) tick();
        LW_STALL = 1'b1; DEC_FLUSH = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        LW_STALL = 1'b0; DEC_FLUSH = 1'b0; redirect_pc = '0;
        chk("fbs_valid", 32'(dec_valid), 32'd0);
        chk("fbs_ir", dec_ir, 32'd0);
        tick(); tick();
        chk("redir_f3_pc", dec_pc, 32'h0000_0200);
        chk("redir_f3_ir", dec_ir, 32'hA5A5_0200);

        // Irregular memory, starting just below the address wrap.
        DEC_FLUSH = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        DEC_FLUSH = 1'b0;
        gnt_rand = 1'b1; del_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i >= 80) begin
                LW_STALL    = ($urandom_range(0, 3) == 0);
                DEC_FLUSH   = ($urandom_range(0, 31) == 0);
                redirect_pc = $urandom;
            end
            tick();
            if (dec_valid) begin
                if (prev_pc == 32'hFFFF_FFFC && dec_pc == 32'd0) wrapped = 1'b1;
                prev_pc = dec_pc;
            end
        end
        LW_STALL = 1'b0; DEC_FLUSH = 1'b0;
        chk("wrap_seen", 32'(wrapped), 32'd1);

        // Reset mid-stream with a full queue.
        gnt_rand = 1'b0; del_rand = 1'b0; fix_del = 1;
        repeat (8) tick();
        LW_STALL = 1'b1;
        repeat (4) tick();
        chk("full_before_rst", 32'(imem_req), 32'd0);
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 32'(dec_valid), 32'd0);
        chk("midrst_pc", dec_pc, 32'd0);
        chk("midrst_ir", dec_ir, 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        LW_STALL = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        #1;
        chk("rerst_req", 32'(imem_req), 32'd1);
        chk("rerst_addr", imem_addr, RV);
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
